vga_vram_scheduler: RTL and testbench

- Shares one single-port video RAM between two users:
  - the display pixel fetch, driven by the VGA sync pulse generator's x/y/active outputs;
  - a draw-engine write requester, using a valid/ready handshake.
- The display has absolute priority during the active region. Writes commit only in blanking.
- Sits between the sync generator, the VRAM and the draw engine. It emits sync/active/pixel outputs re-aligned to the RAM read latency.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_vram_scheduler_if.sv | 25 ++
 rtl/vga_delay_pipe.sv | 30 +++
 rtl/vga_vram_scheduler.sv | 145 ++++++++++++++
 tb/tb_vga_vram_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA video-RAM scheduler.
package vga_pkg;

  localparam int unsigned HActive   = 640;
  localparam int unsigned HTotal    = 800;
  localparam int unsigned VActive   = 480;
  localparam int unsigned VTotal    = 525;
  localparam int unsigned VramAddrW = 19;
  localparam int unsigned VramDataW = 8;

  typedef enum logic {
    SYNC  = 1'b0,
    FETCH = 1'b1
  } sched_state_e;

  function automatic int unsigned num_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/vga_vram_scheduler_if.sv
// Draw-engine write port: valid/ready request plus a dropped-write error pulse.
interface vga_vram_scheduler_if
  import vga_pkg::*;
#(
  parameter int unsigned AddrW = VramAddrW,
  parameter int unsigned DataW = VramDataW
);

  logic             wr_valid;
  logic             wr_ready;
  logic [AddrW-1:0] wr_addr;
  logic [DataW-1:0] wr_data;
  logic             wr_err;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, wr_err
  );

endinterface

// File: rtl/vga_delay_pipe.sv
// N-stage register delay line with asynchronous active-low reset.
module vga_delay_pipe #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Depth-1:0][Width-1:0] stage_q;

  for (genvar g = 0; g < Depth; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stage_q[g] <= '0;
        else         stage_q[g] <= d_i;
      end
    end else begin : g_next
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stage_q[g] <= '0;
        else         stage_q[g] <= stage_q[g-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_vram_scheduler.sv
// Arbitrates one single-port VRAM between display fetch (priority while active) and
// draw-engine writes (committed only in blanking); realigns sync/active to read latency.
module vga_vram_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH_ACTIVE  = HActive,
  parameter int unsigned HEIGHT_ACTIVE = VActive,
  parameter int unsigned ADDR_W        = VramAddrW,
  parameter int unsigned DATA_W        = VramDataW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hsync,
  input  logic                i_vsync,
  input  logic [10:0]         i_x,
  input  logic [10:0]         i_y,
  input  logic                i_active,
  vga_vram_scheduler_if.slave wr_if,
  output logic                o_ram_en,
  output logic                o_ram_we,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W-1:0]   o_ram_wdata,
  input  logic [DATA_W-1:0]   i_ram_rdata,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_active,
  output logic [DATA_W-1:0]   o_pixel,
  output logic                o_frame_start
);

  localparam int unsigned      NumPix  = num_pixels(WIDTH_ACTIVE, HEIGHT_ACTIVE);
  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NumPix - 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_err_q, wr_err_d;

  logic              frame0, rd_issue, addr_ok, commit_now, wr_ready, handshake, act_dly;
  logic [ADDR_W-1:0] rd_addr;

  assign frame0     = (i_x == '0) && (i_y == '0);
  // The origin pixel is fetched even from SYNC so the first line is not lost.
  assign rd_issue   = i_active && ((state_q == FETCH) || frame0);
  assign rd_addr    = frame0 ? '0 : rd_cnt_q;
  assign addr_ok    = 32'(hold_addr_q) < NumPix;
  assign commit_now = hold_full_q && !rd_issue && ((state_q == SYNC) || !i_active);
  assign wr_ready   = i_rst_n && (!hold_full_q || commit_now);
  assign handshake  = wr_if.wr_valid && wr_ready;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    hold_full_d = hold_full_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_err_d    = 1'b0;

    if (frame0) state_d = FETCH;

    if (frame0) begin
      rd_cnt_d = rd_issue ? ADDR_W'(1) : '0;
    end else if (rd_issue) begin
      rd_cnt_d = (rd_cnt_q == LastPix) ? '0 : rd_cnt_q + ADDR_W'(1);
    end

    if (commit_now) hold_full_d = 1'b0;
    if (handshake) begin
      hold_full_d = 1'b1;
      hold_addr_d = wr_if.wr_addr;
      hold_data_d = wr_if.wr_data;
    end

    if (rd_issue) begin
      ram_en_d   = 1'b1;
      ram_addr_d = rd_addr;
    end else if (commit_now) begin
      if (addr_ok) begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = hold_addr_q;
        ram_wdata_d = hold_data_q;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= SYNC;
      rd_cnt_q    <= '0;
      hold_full_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      hold_full_q <= hold_full_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wr_err_q    <= wr_err_d;
    end
  end

  vga_delay_pipe #(
    .Width(3),
    .Depth(2)
  ) u_align (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .d_i   ({i_hsync, i_vsync, rd_issue}),
    .q_o   ({o_hsync, o_vsync, act_dly})
  );

  assign o_active       = act_dly;
  assign o_pixel        = act_dly ? i_ram_rdata : '0;
  assign o_frame_start  = frame0 && i_rst_n;
  assign o_ram_en       = ram_en_q;
  assign o_ram_we       = ram_we_q;
  assign o_ram_addr     = ram_addr_q;
  assign o_ram_wdata    = ram_wdata_q;
  assign wr_if.wr_ready = wr_ready;
  assign wr_if.wr_err   = wr_err_q;

endmodule

// File: tb/tb_vga_vram_scheduler.sv
// Scoreboard bench for vga_vram_scheduler on a reduced 16x4 raster (28x6 total).
module tb_vga_vram_scheduler;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int HT   = 28;
  localparam int VT   = 6;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsync, vsync, active;
  logic [10:0]   x, y;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          o_hsync, o_vsync, o_active, o_frame_start;
  logic [DW-1:0] o_pixel;

  vga_vram_scheduler_if #(.AddrW(AW), .DataW(DW)) wr_if ();

  vga_vram_scheduler #(
    .WIDTH_ACTIVE (W),
    .HEIGHT_ACTIVE(H),
    .ADDR_W       (AW),
    .DATA_W       (DW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hsync      (hsync),
    .i_vsync      (vsync),
    .i_x          (x),
    .i_y          (y),
    .i_active     (active),
    .wr_if        (wr_if),
    .o_ram_en     (ram_en),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_active     (o_active),
    .o_pixel      (o_pixel),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, preloaded with data = addr[7:0].
  logic [DW-1:0] mem [1 << AW];
  int            shadow [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = DW'(i);
      shadow[i] = i & 255;
    end
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t rd_q[$], px_q[$], wr_q[$], err_q[$];
  int   gx, gy;
  bit   synced;
  logic hp1, hp2, vp1, vp2;
  int   we_run = 0;
  int   we_run_max = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  exp_t m;
  always @(negedge clk) begin
    if (rst_n) begin
      while (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
        m = rd_q.pop_front();
        chk("rd_missing", -1, m.val);
      end
      while (px_q.size() != 0 && px_q[0].cyc < cyc) begin
        m = px_q.pop_front();
        chk("px_missing", -1, m.val);
      end
      while (err_q.size() != 0 && err_q[0].cyc < cyc) begin
        m = err_q.pop_front();
        chk("err_missing", -1, m.val);
      end
      while (wr_q.size() != 0 && wr_q[0].cyc >= 0 && wr_q[0].cyc < cyc) begin
        m = wr_q.pop_front();
        chk("wr_missing", -1, m.val >> 8);
      end
      if (ram_en && !ram_we) begin
        if (rd_q.size() == 0) chk("rd_unexpected", int'(ram_addr), -1);
        else begin
          m = rd_q.pop_front();
          chk("rd_addr", int'(ram_addr), m.val);
          chk("rd_cycle", cyc, m.cyc);
        end
      end
      if (ram_en && ram_we) begin
        we_run++;
        if (we_run > we_run_max) we_run_max = we_run;
        if (wr_q.size() == 0) chk("wr_unexpected", int'(ram_addr), -1);
        else begin
          m = wr_q.pop_front();
          chk("wr_addr", int'(ram_addr), m.val >> 8);
          chk("wr_data", int'(ram_wdata), m.val & 255);
          if (m.cyc >= 0) chk("wr_cycle", cyc, m.cyc);
        end
      end else begin
        we_run = 0;
      end
      if (wr_if.wr_err) begin
        if (err_q.size() == 0) chk("err_unexpected", cyc, -1);
        else begin
          m = err_q.pop_front();
          chk("err_cycle", cyc, m.cyc);
        end
      end
      if (o_active) begin
        if (px_q.size() == 0) chk("px_unexpected", int'(o_pixel), -1);
        else begin
          m = px_q.pop_front();
          chk("pixel", int'(o_pixel), m.val);
          chk("pixel_cycle", cyc, m.cyc);
        end
      end else begin
        chk("pixel_blank", int'(o_pixel), 0);
      end
    end
  end

  // One generator cycle: drive, record expectations, sample at negedge, advance.
  task automatic step(input bit v, input int a, input int d, input int tag,
                      output bit hs, output bit rdy);
    int ad;
    x      = 11'(gx);
    y      = 11'(gy);
    active = (gx < W) && (gy < H);
    hsync  = (gx >= 20) && (gx < 23);
    vsync  = (gy == 5);
    wr_if.wr_valid = v;
    wr_if.wr_addr  = AW'(a);
    wr_if.wr_data  = DW'(d);
    if (gx == 0 && gy == 0) synced = 1'b1;
    if (synced && active) begin
      ad = gy * W + gx;
      rd_q.push_back('{cyc: cyc + 1, val: ad});
      px_q.push_back('{cyc: cyc + 2, val: shadow[ad]});
    end
    @(negedge clk);
    chk("frame_start", int'(o_frame_start), int'(gx == 0 && gy == 0));
    chk("hsync_dly", int'(o_hsync), int'(hp2));
    chk("vsync_dly", int'(o_vsync), int'(vp2));
    hp2 = hp1; hp1 = hsync;
    vp2 = vp1; vp1 = vsync;
    rdy = wr_if.wr_ready;
    hs  = v && rdy;
    if (hs) begin
      if (a < NPIX) begin
        wr_q.push_back('{cyc: tag, val: a * 256 + d});
        shadow[a] = d;
      end else begin
        err_q.push_back('{cyc: cyc + 2, val: a});
      end
    end
    @(posedge clk);
    #1;
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) gy = 0;
    end
  endtask

  task automatic run_until(input int tx, input int ty);
    bit hs, rdy;
    for (int n = 0; n < 400; n++) begin
      if (gx == tx && gy == ty) return;
      step(1'b0, 0, 0, -1, hs, rdy);
    end
    chk("run_until_bound", gx * 100 + gy, tx * 100 + ty);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_en"}, int'(ram_en), 0);
    chk({tag, "_ram_we"}, int'(ram_we), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    chk({tag, "_wr_ready"}, int'(wr_if.wr_ready), 0);
    chk({tag, "_wr_err"}, int'(wr_if.wr_err), 0);
    chk({tag, "_hsync"}, int'(o_hsync), 0);
    chk({tag, "_vsync"}, int'(o_vsync), 0);
    chk({tag, "_active"}, int'(o_active), 0);
    chk({tag, "_pixel"}, int'(o_pixel), 0);
    chk({tag, "_frame_start"}, int'(o_frame_start), 0);
  endtask

  initial begin
    bit hs, rdy;
    int saved;
    rst_n  = 1'b1;
    gx     = 5;
    gy     = 1;
    synced = 1'b0;
    hp1 = 1'b0; hp2 = 1'b0; vp1 = 1'b0; vp2 = 1'b0;
    x = 11'd5; y = 11'd1; active = 1'b1; hsync = 1'b0; vsync = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por_hold");
    rst_n = 1'b1;

    // Released mid-frame: no reads until the origin, then two full frames.
    run_until(0, 0);
    step(1'b0, 0, 0, -1, hs, rdy);
    run_until(0, 0);
    step(1'b0, 0, 0, -1, hs, rdy);
    run_until(0, 0);

    // Write during active: captured at once, committed at first blanking cycle.
    run_until(2, 3);
    step(1'b1, 40, 8'h5A, cyc + 15, hs, rdy);
    chk("wr40_accept", int'(hs), 1);
    for (int xi = 3; xi <= 16; xi++) begin
      step(1'b1, 41, 8'hA5, cyc + 2, hs, rdy);
      chk("wr41_ready_held", int'(hs), int'(xi == 16));
    end

    // Back-to-back burst in horizontal blanking of the next frame.
    run_until(0, 0);
    run_until(16, 0);
    we_run_max = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 20 + k, 8'h30 + k, cyc + 2, hs, rdy);
      chk("burst_accept", int'(hs), 1);
    end
    run_until(2, 4);
    chk("burst_we_run", we_run_max, 8);

    // Out-of-range write: error pulse, no RAM access, ready again next cycle.
    step(1'b1, NPIX, 8'h11, -1, hs, rdy);
    chk("oor_accept", int'(hs), 1);
    step(1'b0, 0, 0, -1, hs, rdy);
    chk("ready_after_err", int'(rdy), 1);

    // Reset mid-line in FETCH with a held write.
    run_until(4, 1);
    saved = shadow[50];
    step(1'b1, 50, 8'h77, -1, hs, rdy);
    chk("held_accept", int'(hs), 1);
    step(1'b0, 0, 0, -1, hs, rdy);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    rd_q.delete();
    px_q.delete();
    wr_q.delete();
    err_q.delete();
    shadow[50] = saved;
    synced = 1'b0;
    hp1 = 1'b0; hp2 = 1'b0; vp1 = 1'b0; vp2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    gx = 12;
    gy = 1;
    run_until(0, 0);
    step(1'b0, 0, 0, -1, hs, rdy);
    run_until(0, 0);
    run_until(0, 4);
    repeat (4) step(1'b0, 0, 0, -1, hs, rdy);

    chk("rd_left", rd_q.size(), 0);
    chk("px_left", px_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("err_left", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
